seq_subtractor: RTL and testbench



---
 rtl/sub_pkg.sv | 33 +++
 rtl/sub_chunk.sv | 36 +++
 rtl/seq_subtractor.sv | 213 +++++++++++++++++++++
 tb/tb_seq_subtractor.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sub_pkg
// Description : Shared definitions for the sequential subtractor.
//               Holds the FSM state encoding, the default operand/chunk
//               widths, the chunk-count derivation and the configuration
//               legality check used at elaboration time.
// Revision    : 1.0 - initial release
// ============================================================================
package sub_pkg;

    // Default operand width and bits processed per clock.
    localparam int c_default_width = 32;
    localparam int c_default_chunk = 8;

    // FSM state encoding (explicit 2-bit width).
    typedef logic [1:0] state_t;
    localparam state_t c_st_idle = 2'd0;
    localparam state_t c_st_run  = 2'd1;
    localparam state_t c_st_done = 2'd2;

    // Number of chunk cycles needed for one full-width subtraction.
    function automatic int calc_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A configuration is legal only if WIDTH splits into whole chunks.
    function automatic bit chunk_cfg_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sub_chunk.sv
`default_nettype none
// ============================================================================
// Module      : sub_chunk
// Description : Combinational CHUNK-bit subtractor with borrow in/out.
//               d = a - b - bin (mod 2^CHUNK), bout = 1 when the true
//               difference is negative.
// Ports       : a, b  - CHUNK-bit operands
//               bin   - borrow in from the previous (lower) chunk
//               d     - CHUNK-bit difference
//               bout  - borrow out to the next (higher) chunk
// Revision    : 1.0 - initial release
// ============================================================================
module sub_chunk
    import sub_pkg::*;
#(
    parameter int CHUNK = c_default_chunk
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bin,
    output logic [CHUNK-1:0] d,
    output logic             bout
);

    // One extra bit catches the sign of the difference: a - b - bin lies in
    // [-2^CHUNK, 2^CHUNK - 1], so the top bit is set exactly on a borrow.
    logic [CHUNK:0] w_diff;

    always_comb begin
        w_diff = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};
        d      = w_diff[CHUNK-1:0];
        bout   = w_diff[CHUNK];
    end

endmodule
`default_nettype wire

// File: rtl/seq_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : seq_subtractor
// Description : Multi-cycle subtractor computing Y = A - B over WIDTH bits,
//               CHUNK bits per clock, with the borrow carried in a register
//               between cycles. A start/busy/done handshake frames each
//               operation; latency from accepting edge to done is
//               WIDTH/CHUNK cycles.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               start      - request, sampled only while not busy
//               A, B       - minuend / subtrahend, latched on acceptance
//               busy       - operation in progress
//               done       - one-cycle result-valid pulse
//               Y          - A - B mod 2^WIDTH, held until next completion
//               borrow     - final borrow-out (unsigned A < B)
//               zero       - Y == 0
//               overflow   - signed overflow (only with SUB_OVERFLOW_EN)
// Options     : SUB_OVERFLOW_EN - define to add the overflow port/logic.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int CHUNK = c_default_chunk
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y,
    output logic             borrow,
    output logic             zero
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int c_n  = calc_chunks(WIDTH, CHUNK);
    localparam int c_kw = (c_n > 1) ? $clog2(c_n) : 1;
    localparam logic [c_kw-1:0] c_k_last = c_kw'(c_n - 1);

    if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_error
        $error("seq_subtractor: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)",
               WIDTH, CHUNK);
    end

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [c_kw-1:0]  r_k;
    logic             r_bin;

    logic [WIDTH-1:0] r_y;
    logic             r_borrow;
    logic             r_zero;

    logic [31:0]      w_base;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_res_next;

    // ------------------------------------------------------------------
    // Chunk selection and the single shared chunk subtractor
    // ------------------------------------------------------------------
    assign w_base    = 32'(r_k) * 32'(CHUNK);
    assign w_a_chunk = r_a[w_base +: CHUNK];
    assign w_b_chunk = r_b[w_base +: CHUNK];

    sub_chunk #(
        .CHUNK (CHUNK)
    ) u_sub_chunk (
        .a    (w_a_chunk),
        .b    (w_b_chunk),
        .bin  (r_bin),
        .d    (w_d),
        .bout (w_bout)
    );

    // ------------------------------------------------------------------
    // Result accumulation. Each new chunk enters at the top and older
    // chunks move down, so after N cycles chunk 0 sits in the LSBs. Only
    // WIDTH-CHUNK bits need storage: the newest chunk comes straight from
    // the subtractor on the final cycle.
    // ------------------------------------------------------------------
    if (CHUNK == WIDTH) begin : g_res_single
        assign w_res_next = w_d;
    end else begin : g_res_shift
        logic [WIDTH-CHUNK-1:0] r_res;

        assign w_res_next = {w_d, r_res};

        always_ff @(posedge clk) begin
            if (rst) begin
                r_res <= '0;
            end else if (w_accept) begin
                r_res <= '0;
            end else if (r_state == c_st_run) begin
                r_res <= w_res_next[WIDTH-1:CHUNK];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register + next-state logic
    // ------------------------------------------------------------------
    assign w_last = (r_state == c_st_run) && (r_k == c_k_last);

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = c_st_run;
                end
            end
            c_st_run: begin
                // start is deliberately not looked at here: no queuing.
                if (w_last) begin
                    w_state_next = c_st_done;
                end
            end
            c_st_done: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = c_st_run;
                end else begin
                    w_state_next = c_st_idle;
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Operand latch, chunk counter, running borrow and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_k      <= '0;
            r_bin    <= 1'b0;
            r_y      <= '0;
            r_borrow <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            r_a   <= A;
            r_b   <= B;
            r_k   <= '0;
            r_bin <= 1'b0;
        end else if (r_state == c_st_run) begin
            r_bin <= w_bout;
            r_k   <= r_k + c_kw'(1);
            // Visible outputs move only when the last chunk completes.
            if (w_last) begin
                r_y      <= w_res_next;
                r_borrow <= w_bout;
                r_zero   <= (w_res_next == '0);
            end
        end
    end

`ifdef SUB_OVERFLOW_EN
    logic r_overflow;

    // Signed overflow: operands of differing sign and a result whose sign
    // disagrees with the minuend.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_last) begin
            r_overflow <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                          (w_res_next[WIDTH-1] != r_a[WIDTH-1]);
        end
    end

    assign overflow = r_overflow;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy   = (r_state == c_st_run);
    assign done   = (r_state == c_st_done);
    assign Y      = r_y;
    assign borrow = r_borrow;
    assign zero   = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_seq_subtractor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_seq_subtractor
// Description : Self-checking bench for seq_subtractor. A CHUNK=8 instance
//               is driven through a table of directed vectors and
//               hand-written handshake/reset sequences; CHUNK=1 and
//               CHUNK=32 instances share the inputs for a random sweep
//               against a reference A-B.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_subtractor;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int N     = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst;
    logic             r_start;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    logic             w_busy,  w_done,  w_borrow,  w_zero;
    logic             w_busy1, w_done1, w_borrow1, w_zero1;
    logic             w_busy3, w_done3, w_borrow3, w_zero3;
    logic [WIDTH-1:0] w_y, w_y1, w_y3;
`ifdef SUB_OVERFLOW_EN
    logic             w_ovf, w_ovf1, w_ovf3;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_subtractor #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst), .start(r_start), .A(r_a), .B(r_b),
        .busy(w_busy), .done(w_done), .Y(w_y), .borrow(w_borrow), .zero(w_zero)
`ifdef SUB_OVERFLOW_EN
        , .overflow(w_ovf)
`endif
    );

    seq_subtractor #(.WIDTH(WIDTH), .CHUNK(1)) dut_c1 (
        .clk(clk), .rst(rst), .start(r_start), .A(r_a), .B(r_b),
        .busy(w_busy1), .done(w_done1), .Y(w_y1), .borrow(w_borrow1), .zero(w_zero1)
`ifdef SUB_OVERFLOW_EN
        , .overflow(w_ovf1)
`endif
    );

    seq_subtractor #(.WIDTH(WIDTH), .CHUNK(WIDTH)) dut_c32 (
        .clk(clk), .rst(rst), .start(r_start), .A(r_a), .B(r_b),
        .busy(w_busy3), .done(w_done3), .Y(w_y3), .borrow(w_borrow3), .zero(w_zero3)
`ifdef SUB_OVERFLOW_EN
        , .overflow(w_ovf3)
`endif
    );

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] y;
        logic             brw;
        logic             zr;
        logic             ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present operands with start for one accepting edge; returns #1 after it.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        r_a     = a;
        r_b     = b;
        r_start = 1'b1;
        @(posedge clk);
        #1;
        r_start = 1'b0;
    endtask

    // Count edges until done on the CHUNK=8 instance; -1 if the budget expires.
    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            #1;
            if (w_done) begin
                lat = c;
                break;
            end
        end
    endtask

    // Count done pulses over a window of edges.
    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            if (w_done) pulses++;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lat2, pulses;
        logic [WIDTH-1:0] ra, rb, ry;
        logic             rovf;
        int lat1, lat8, lat32;

        vecs[0] = '{32'h0000_0010, 32'h0000_0001, 32'h0000_000F, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hCC79_6877, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{32'h1234_5678, 32'hDEAD_BEEF, 32'h3386_9789, 1'b1, 1'b0, 1'b0};

        // ---------------- reset, with start asserted alongside ------------
        rst     = 1'b1;
        r_start = 1'b1;
        r_a     = 32'h0000_0005;
        r_b     = 32'h0000_0001;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   w_busy,   1'b0);
        check("reset_done",   w_done,   1'b0);
        check("reset_y",      w_y,      32'h0);
        check("reset_borrow", w_borrow, 1'b0);
        check("reset_zero",   w_zero,   1'b0);
`ifdef SUB_OVERFLOW_EN
        check("reset_ovf",    w_ovf,    1'b0);
`endif
        @(negedge clk);
        r_start = 1'b0;
        rst     = 1'b0;

        // ---------------- directed vector table ----------------------------
        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_busy_start", i), w_busy, 1'b1);
            wait_done(N + 4, lat);
            check($sformatf("v%0d_latency", i), lat, N);
            check($sformatf("v%0d_y", i), w_y, vecs[i].y);
            check($sformatf("v%0d_borrow", i), w_borrow, vecs[i].brw);
            check($sformatf("v%0d_zero", i), w_zero, vecs[i].zr);
`ifdef SUB_OVERFLOW_EN
            check($sformatf("v%0d_ovf", i), w_ovf, vecs[i].ovf);
`endif
            check($sformatf("v%0d_busy_done", i), w_busy, 1'b0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_width", i), w_done, 1'b0);
        end

        // ---------------- start during RUN is ignored ----------------------
        start_op(32'h0000_0064, 32'h0000_0001);
        @(negedge clk);
        r_a     = 32'h0000_0005;
        r_b     = 32'h0000_0007;
        r_start = 1'b1;
        @(posedge clk);
        #1;
        r_start = 1'b0;
        wait_done(N + 4, lat);
        check("ign_latency", lat, N - 1);
        check("ign_y", w_y, 32'h0000_0063);
        check("ign_borrow", w_borrow, 1'b0);
        count_done(N + 4, pulses);
        check("ign_no_queued_op", pulses, 0);

        // ---------------- back-to-back with start held ---------------------
        @(negedge clk);
        r_a     = 32'h0000_0014;
        r_b     = 32'h0000_0003;
        r_start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(N + 4, lat);
        check("b2b_first_latency", lat, N);
        check("b2b_first_y", w_y, 32'h0000_0011);
        r_a = 32'h0000_1000;
        r_b = 32'h0000_0001;
        @(posedge clk);
        #1;
        r_start = 1'b0;
        check("b2b_accept_busy", w_busy, 1'b1);
        check("b2b_accept_done_low", w_done, 1'b0);
        wait_done(N + 4, lat2);
        check("b2b_done_spacing", lat2 + 1, N + 1);
        check("b2b_second_y", w_y, 32'h0000_0FFF);

        // ---------------- reset in the middle of RUN -----------------------
        start_op(32'h0000_0050, 32'h0000_0010);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", w_busy, 1'b0);
        check("midrst_done", w_done, 1'b0);
        check("midrst_y", w_y, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        count_done(N + 4, pulses);
        check("midrst_no_done", pulses, 0);
        start_op(32'h0000_0050, 32'h0000_0010);
        wait_done(N + 4, lat);
        check("midrst_fresh_latency", lat, N);
        check("midrst_fresh_y", w_y, 32'h0000_0040);

        // Let the CHUNK=1 instance finish whatever it picked up.
        repeat (WIDTH + 4) @(posedge clk);

        // ---------------- random sweep over CHUNK = 1, 8, 32 ---------------
        for (int t = 0; t < 1000; t++) begin
            ra   = $urandom;
            rb   = $urandom;
            ry   = ra - rb;
            rovf = (ra[WIDTH-1] != rb[WIDTH-1]) && (ry[WIDTH-1] != ra[WIDTH-1]);
            lat1 = -1;
            lat8 = -1;
            lat32 = -1;
            start_op(ra, rb);
            for (int c = 1; c <= WIDTH + 4; c++) begin
                @(posedge clk);
                #1;
                if (w_done1 && lat1 < 0) begin
                    lat1 = c;
                    check($sformatf("sw%0d_c1_y", t), w_y1, ry);
                    check($sformatf("sw%0d_c1_borrow", t), w_borrow1, ra < rb);
                    check($sformatf("sw%0d_c1_zero", t), w_zero1, ry == 0);
`ifdef SUB_OVERFLOW_EN
                    check($sformatf("sw%0d_c1_ovf", t), w_ovf1, rovf);
`endif
                end
                if (w_done && lat8 < 0) begin
                    lat8 = c;
                    check($sformatf("sw%0d_c8_y", t), w_y, ry);
                    check($sformatf("sw%0d_c8_borrow", t), w_borrow, ra < rb);
                    check($sformatf("sw%0d_c8_zero", t), w_zero, ry == 0);
`ifdef SUB_OVERFLOW_EN
                    check($sformatf("sw%0d_c8_ovf", t), w_ovf, rovf);
`endif
                end
                if (w_done3 && lat32 < 0) begin
                    lat32 = c;
                    check($sformatf("sw%0d_c32_y", t), w_y3, ry);
                    check($sformatf("sw%0d_c32_borrow", t), w_borrow3, ra < rb);
                    check($sformatf("sw%0d_c32_zero", t), w_zero3, ry == 0);
`ifdef SUB_OVERFLOW_EN
                    check($sformatf("sw%0d_c32_ovf", t), w_ovf3, rovf);
`endif
                end
                if (lat1 >= 0 && lat8 >= 0 && lat32 >= 0) break;
            end
            check($sformatf("sw%0d_c1_latency", t), lat1, WIDTH);
            check($sformatf("sw%0d_c8_latency", t), lat8, WIDTH / 8);
            check($sformatf("sw%0d_c32_latency", t), lat32, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
